mem_arb: RTL



---
 rtl/mem_arb_if.sv | 46 ++++
 rtl/mem_arb.sv | 114 +++++++++++
 2 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the mem_arb sequencer and the shared memory pins.
interface mem_arb_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_ack;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_ack;
    logic [31:0] m1_rdata;

    logic [31:0] Addr;
    logic [31:0] W_data;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] R_data;
    logic        busy;
    logic        owner;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  R_data,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output Addr, W_data, MemRd, MemWr, busy, owner
    );

    // Requester / memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output R_data,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  Addr, W_data, MemRd, MemWr, busy, owner
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port arbiter/sequencer for one shared memory; strobes held MEM_LAT cycles, one-cycle ack.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module mem_arb #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("mem_arb: MEM_LAT must be in 1..15");
    end

    localparam logic [3:0] CntLoad = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q;
    logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
    logic [3:0]  cnt_q;
    logic        we_q, owner_q, busy_q, rd_q, wr_q;
    logic        gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic        win_d;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On contention the port that did not win last time goes next
        if (bus.m0_req && bus.m1_req) win_d = ~owner_q;
        else                          win_d = bus.m1_req;
`else
        win_d = ~bus.m0_req;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            owner_q  <= 1'b1;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.m0_req || bus.m1_req) begin
                        state_q <= StAccess;
                        owner_q <= win_d;
                        cnt_q   <= CntLoad;
                        busy_q  <= 1'b1;
                        addr_q  <= win_d ? bus.m1_addr  : bus.m0_addr;
                        wdata_q <= win_d ? bus.m1_wdata : bus.m0_wdata;
                        we_q    <= win_d ? bus.m1_we    : bus.m0_we;
                        rd_q    <= win_d ? ~bus.m1_we   : ~bus.m0_we;
                        wr_q    <= win_d ? bus.m1_we    : bus.m0_we;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ack0_q  <= ~owner_q;
                        ack1_q  <= owner_q;
                        if (!we_q) begin
                            if (owner_q) rdata1_q <= bus.R_data;
                            else         rdata0_q <= bus.R_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Addr     = addr_q;
    assign bus.W_data   = wdata_q;
    assign bus.MemRd    = rd_q;
    assign bus.MemWr    = wr_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.m0_gnt   = gnt0_q;
    assign bus.m1_gnt   = gnt1_q;
    assign bus.m0_ack   = ack0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

endmodule
